reg_file_sb: RTL and testbench
==============================

# reg_file_sb

Parametrised multi-read-port register file with a per-register pending-write scoreboard and a sequenced bulk-clear engine. It sits in the decode/writeback stages of the pipelined MIPS core. Decode reads operands and checks hazards through `rd_busy`. Issue claims destination registers, and writeback stores results and releases the claims.

## Interface
Parameters:
- `DATA_W`, 32, register width in bits.
- `ADDR_W`, 5, register address width; depth is `DEPTH = 2**ADDR_W`.
- `NRD`, 2, number of read ports (≥1).
- `R0_ZERO`, 1, when 1 register 0 reads as zero, ignores writes and is never busy.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rd_addr` in `NRD*ADDR_W`: read addresses; port k uses bits `[k*ADDR_W +: ADDR_W]`.
- `rd_data` out `NRD*DATA_W`: read data; port k uses bits `[k*DATA_W +: DATA_W]`.
- `rd_busy` out `NRD`: scoreboard bit of the addressed register, one bit per port.
- `wr_en` in 1: writeback strobe.
- `wr_addr` in `ADDR_W`: writeback register.
- `wr_data` in `DATA_W`: writeback data.
- `claim_en` in 1: issue strobe; marks `claim_addr` pending.
- `claim_addr` in `ADDR_W`: register claimed by the issuing instruction.
- `clr_req` in 1: request a bulk clear of all registers and scoreboard bits.
- `clr_busy` out 1: high while the clear engine is sweeping.

## Operation
- **Reset** (`rst`=1, any time, including mid-clear):
  - all registers are 0 and all scoreboard bits are 0;
  - state goes to IDLE, the sweep counter goes to 0 and `clr_busy` goes to 0.
- **Reset output values:** `rd_data` is 0 on every port, `rd_busy` is 0.
- **States:** IDLE and CLEAR.
- **Write (IDLE):** on a rising edge with `wr_en`=1:
  - `mem[wr_addr]` takes `wr_data`, and `sb[wr_addr]` is cleared;
  - when `R0_ZERO`=1 and `wr_addr`=0, the write is dropped.
- **Claim (IDLE):** on a rising edge with `claim_en`=1:
  - `sb[claim_addr]` is set;
  - when `R0_ZERO`=1 and `claim_addr`=0, the claim is ignored.
- **Claim and write to the same address in the same cycle:** the data is written and the claim wins, so `sb` stays 1 (a newer producer is pending).
- **Claim and write to different addresses in the same cycle:** both take effect independently.
- **Read:** combinational on every port.
  - `rd_data` is `mem[rd_addr]` and `rd_busy` is `sb[rd_addr]`.
  - Address 0 with `R0_ZERO`=1 gives data 0 and busy 0.
  - Multiple ports may read the same address.
- **Clear request:** `clr_req`=1 sampled in IDLE moves the block to CLEAR with counter 0.
  - A `wr_en` or `claim_en` in that same request cycle is still performed.
- **CLEAR sweep:** each cycle, `mem[cnt]` and `sb[cnt]` are set to 0 and `cnt` increments.
  - After the cycle that clears `cnt = DEPTH-1`, the counter wraps to 0 and the state returns to IDLE.
- **While in CLEAR:**
  - `wr_en`, `claim_en` and `clr_req` are ignored and dropped; they are not queued.
  - Reads return current contents, so entries not yet swept keep their old values.

## Timing
- Write to read latency is 1 cycle without bypass: data written at edge N is visible on `rd_data` after edge N.
- Claim to busy latency is 1 cycle: `rd_busy` rises after the claiming edge.
- `clr_busy` rises after the edge that samples `clr_req` and stays high for exactly `DEPTH` cycles.
- `clr_req` to first accepted write is `DEPTH+1` edges.
- No read-port stalls; every output is valid in the same cycle as its address.

## Configuration
- **`REG_FILE_SB_BYPASS_EN` defined:** write-through forwarding in IDLE.
  - Applies when `wr_en`=1 and `rd_addr[k]`=`wr_addr` (not a dropped r0 write).
  - Port k then shows `rd_data`=`wr_data` combinationally in the same cycle.
  - Port k shows `rd_busy`=0, unless `claim_en`=1 with `claim_addr`=`wr_addr`, in which case `rd_busy`=1.
  - No bypass while in CLEAR.
- **Macro undefined:** no forwarding; reads reflect registered state only (latency as in Timing).

## Test plan
- **Reset then read:** assert `rst` mid-cycle with registers holding 0xDEADBEEF → `rd_data`=0 and `rd_busy`=0 on all ports immediately; `clr_busy`=0.
- **Write and read-back:** write 0x12345678 to r5, then read r5 on port 0 and r5 on port 1 → both show 0x12345678 the next cycle. Write 0xFFFFFFFF to r0 → r0 still reads 0.
- **Scoreboard:**
  - Claim r7 → `rd_busy`=1 next cycle.
  - Write r7=0xA5 → busy 0 and data 0xA5.
  - Simultaneous claim r9 and write r9=0x3C → data 0x3C, busy 1.
- **Bypass (macro defined):** in one cycle, `wr_en` with r3=0x55AA and `rd_addr0`=r3 → `rd_data0`=0x55AA and `rd_busy0`=0 in the same cycle. With the macro undefined, the old value is shown until the next edge.
- **Bulk clear:**
  - Fill r1..r31 with their index and claim r4, then pulse `clr_req` → `clr_busy` high for 32 cycles.
  - A `wr_en` to r2=0x77 during the sweep is dropped.
  - Afterwards, all registers read 0 and all busy bits are 0.
- **Reset mid-clear:** assert `rst` at sweep cycle 10 → `clr_busy`=0 immediately, all registers 0, state IDLE. A write is accepted on the first edge after `rst` deasserts.

Source files
------------

// File: rtl/reg_file_sb.sv
// Multi-read-port register file with a pending-write scoreboard and a sequenced bulk-clear sweep.
// Define REG_FILE_SB_BYPASS_EN to forward same-cycle writeback data to matching read ports.
module reg_file_sb #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int NRD     = 2,
  parameter int R0_ZERO = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NRD*ADDR_W-1:0]   rd_addr,
  output logic [NRD*DATA_W-1:0]   rd_data,
  output logic [NRD-1:0]          rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    claim_en,
  input  logic [ADDR_W-1:0]       claim_addr,
  input  logic                    clr_req,
  output logic                    clr_busy
);

  localparam int DEPTH = 2**ADDR_W;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   cnt, cnt_nxt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DEPTH-1:0]    sb;
  logic                wr_ok;
  logic                claim_ok;

  // Register 0 is hardwired when R0_ZERO is set, so its writes and claims are dropped.
  assign wr_ok    = wr_en && (state == IDLE) && !((R0_ZERO != 0) && (wr_addr == '0));
  assign claim_ok = claim_en && (state == IDLE) && !((R0_ZERO != 0) && (claim_addr == '0));
  assign clr_busy = (state == CLEAR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_nxt = CLEAR;
          cnt_nxt   = '0;
        end
      end
      CLEAR: begin
        cnt_nxt = cnt + 1'b1;
        if (cnt == {ADDR_W{1'b1}}) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The claim is applied after the write so a same-address claim leaves the entry pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      sb <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
      sb[cnt]  <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem[wr_addr] <= wr_data;
        sb[wr_addr]  <= 1'b0;
      end
      if (claim_ok) sb[claim_addr] <= 1'b1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              r0;
    assign a  = rd_addr[k*ADDR_W +: ADDR_W];
    assign r0 = (R0_ZERO != 0) && (a == '0);
`ifdef REG_FILE_SB_BYPASS_EN
    logic fwd;
    assign fwd = wr_ok && (a == wr_addr);
    assign rd_data[k*DATA_W +: DATA_W] = r0 ? '0 : (fwd ? wr_data : mem[a]);
    assign rd_busy[k] = r0 ? 1'b0 : (fwd ? (claim_ok && (claim_addr == wr_addr)) : sb[a]);
`else
    assign rd_data[k*DATA_W +: DATA_W] = r0 ? '0 : mem[a];
    assign rd_busy[k] = r0 ? 1'b0 : sb[a];
`endif
  end

endmodule

// File: tb/tb_reg_file_sb.sv
// Self-checking bench for reg_file_sb: array-based model compared every cycle plus directed literal checks.
// Bypass expectations follow REG_FILE_SB_BYPASS_EN when it is defined.
module tb_reg_file_sb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  rd_addr = '0;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wr_en = 1'b0;
  logic [4:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic        claim_en = 1'b0;
  logic [4:0]  claim_addr = '0;
  logic        clr_req = 1'b0;
  logic        clr_busy;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: plain arrays plus a "sweep in progress" flag and how many entries are done.
  logic [31:0] m_mem [32];
  logic        m_sb  [32];
  logic        m_clearing;
  int          m_swept;

  reg_file_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .claim_en(claim_en),
    .claim_addr(claim_addr), .clr_req(clr_req), .clr_busy(clr_busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i] = '0;
        m_sb[i]  = 1'b0;
      end
      m_clearing = 1'b0;
      m_swept    = 0;
    end else if (m_clearing) begin
      m_mem[m_swept] = '0;
      m_sb[m_swept]  = 1'b0;
      m_swept++;
      if (m_swept == 32) m_clearing = 1'b0;
    end else begin
      if (wr_en && wr_addr != 0) begin
        m_mem[wr_addr] = wr_data;
        m_sb[wr_addr]  = 1'b0;
      end
      if (claim_en && claim_addr != 0) m_sb[claim_addr] = 1'b1;
      if (clr_req) begin
        m_clearing = 1'b1;
        m_swept    = 0;
      end
    end
  end

  function automatic logic [32:0] model_read(input logic [4:0] a);
    logic [31:0] d;
    logic        b;
    d = (a == 0) ? 32'h0 : m_mem[a];
    b = (a == 0) ? 1'b0 : m_sb[a];
`ifdef REG_FILE_SB_BYPASS_EN
    if (!m_clearing && wr_en && wr_addr != 0 && a == wr_addr) begin
      d = wr_data;
      b = claim_en && (claim_addr == wr_addr);
    end
`endif
    return {b, d};
  endfunction

  // Every falling edge, all outputs are compared against the model.
  always @(negedge clk) begin
    logic [32:0] e0, e1;
    e0 = model_read(rd_addr[4:0]);
    e1 = model_read(rd_addr[9:5]);
    checkOutput("cyc_data0", rd_data[31:0], e0[31:0]);
    checkOutput("cyc_data1", rd_data[63:32], e1[31:0]);
    checkOutput("cyc_busy0", {31'b0, rd_busy[0]}, {31'b0, e0[32]});
    checkOutput("cyc_busy1", {31'b0, rd_busy[1]}, {31'b0, e1[32]});
    checkOutput("cyc_clr_busy", {31'b0, clr_busy}, {31'b0, m_clearing});
  end

  task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                               input logic ce, input logic [4:0] ca, input logic cr);
    wr_en = we; wr_addr = wa; wr_data = wd;
    claim_en = ce; claim_addr = ca; clr_req = cr;
    @(posedge clk); #1;
    wr_en = 1'b0; claim_en = 1'b0; clr_req = 1'b0;
  endtask

  task automatic setRead(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
    #1;
  endtask

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    setRead(5'd1, 5'd3);
    checkOutput("rst_data0", rd_data[31:0], 32'h0);
    checkOutput("rst_clr_busy", {31'b0, clr_busy}, 32'h0);
    rst = 1'b0;

    // Fill, then reset mid-cycle.
    applyStimulus(1'b1, 5'd1, 32'hDEADBEEF, 1'b1, 5'd3, 1'b0);
    setRead(5'd1, 5'd3);
    checkOutput("pre_rst_data", rd_data[31:0], 32'hDEADBEEF);
    checkOutput("pre_rst_busy", {30'b0, rd_busy}, 32'h2);
    rst = 1'b1; #1;
    checkOutput("midrst_data0", rd_data[31:0], 32'h0);
    checkOutput("midrst_busy", {30'b0, rd_busy}, 32'h0);
    checkOutput("midrst_clr_busy", {31'b0, clr_busy}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    applyStimulus(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 1'b0);
    setRead(5'd5, 5'd5);
    checkOutput("wr_r5_p0", rd_data[31:0], 32'h12345678);
    checkOutput("wr_r5_p1", rd_data[63:32], 32'h12345678);
    applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd0, 1'b0);
    setRead(5'd0, 5'd0);
    checkOutput("r0_data", rd_data[31:0], 32'h0);
    checkOutput("r0_busy", {31'b0, rd_busy[0]}, 32'h0);

    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 1'b0);
    setRead(5'd7, 5'd5);
    checkOutput("claim_r7_busy", {31'b0, rd_busy[0]}, 32'h1);
    applyStimulus(1'b1, 5'd7, 32'hA5, 1'b0, 5'd0, 1'b0);
    checkOutput("wr_r7_busy", {31'b0, rd_busy[0]}, 32'h0);
    checkOutput("wr_r7_data", rd_data[31:0], 32'hA5);
    applyStimulus(1'b1, 5'd9, 32'h3C, 1'b1, 5'd9, 1'b0);
    setRead(5'd9, 5'd9);
    checkOutput("same_r9_data", rd_data[31:0], 32'h3C);
    checkOutput("same_r9_busy", {31'b0, rd_busy[1]}, 32'h1);
    applyStimulus(1'b1, 5'd11, 32'h11, 1'b1, 5'd10, 1'b0);
    setRead(5'd10, 5'd11);
    checkOutput("diff_busy", {30'b0, rd_busy}, 32'h1);
    checkOutput("diff_data", rd_data[63:32], 32'h11);

    // Same-cycle visibility of a write to r3 (previously 0).
    setRead(5'd3, 5'd5);
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h55AA; #1;
`ifdef REG_FILE_SB_BYPASS_EN
    checkOutput("byp_data", rd_data[31:0], 32'h55AA);
`else
    checkOutput("byp_data", rd_data[31:0], 32'h0);
`endif
    checkOutput("byp_busy", {31'b0, rd_busy[0]}, 32'h0);
    @(posedge clk); #1;
    wr_en = 1'b0;
    checkOutput("byp_after", rd_data[31:0], 32'h55AA);

    // Bulk clear with a write in the request cycle and a dropped write mid-sweep.
    for (int i = 1; i < 32; i++) applyStimulus(1'b1, 5'(i), 32'(i), 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 1'b0);
    setRead(5'd4, 5'd30);
    checkOutput("fill_r4_busy", {31'b0, rd_busy[0]}, 32'h1);
    checkOutput("fill_r30", rd_data[63:32], 32'd30);
    setRead(5'd6, 5'd30);
    applyStimulus(1'b1, 5'd6, 32'h66, 1'b0, 5'd0, 1'b1);
    n = 0;
    while (clr_busy && n < 40) begin
      n++;
      if (n == 1) begin
        checkOutput("req_cycle_wr", rd_data[31:0], 32'h66);
        checkOutput("unswept_r30", rd_data[63:32], 32'd30);
      end
      if (n == 5) begin
        wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'h77;
        claim_en = 1'b1; claim_addr = 5'd12;
      end
      @(posedge clk); #1;
      wr_en = 1'b0; claim_en = 1'b0;
    end
    checkOutput("clr_cycles", 32'(n), 32'd32);
    for (int i = 0; i < 32; i++) begin
      setRead(5'(i), 5'(31 - i));
      checkOutput("post_clr_data0", rd_data[31:0], 32'h0);
      checkOutput("post_clr_data1", rd_data[63:32], 32'h0);
      checkOutput("post_clr_busy", {30'b0, rd_busy}, 32'h0);
    end

    // Reset partway through a sweep.
    applyStimulus(1'b1, 5'd20, 32'hCAFE, 1'b0, 5'd0, 1'b0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b1);
    repeat (10) begin @(posedge clk); #1; end
    setRead(5'd20, 5'd8);
    checkOutput("mid_clr_r20", rd_data[31:0], 32'hCAFE);
    checkOutput("mid_clr_busy", {31'b0, clr_busy}, 32'h1);
    rst = 1'b1; #1;
    checkOutput("rst_clr_busy_now", {31'b0, clr_busy}, 32'h0);
    checkOutput("rst_clr_r20", rd_data[31:0], 32'h0);
    rst = 1'b0; #1;
    applyStimulus(1'b1, 5'd8, 32'h88, 1'b0, 5'd0, 1'b0);
    checkOutput("post_rst_wr", rd_data[63:32], 32'h88);
    checkOutput("post_rst_clr_busy", {31'b0, clr_busy}, 32'h0);

    @(posedge clk); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
